multi_channel_timer: RTL and testbench

- Multi-channel programmable timer. Generalises the single free-running divided counter into N independent channels fed by one shared prescaler.
- Each channel has a programmable period, periodic or one-shot mode, a match flag and an interrupt enable.
- Sits on the 8-bit CPU data bus beside the other memory-mapped peripherals. Drives one combined active-high interrupt line to the CPU.

---
 rtl/multi_channel_timer.sv | 136 +++++++++++++
 tb/tb_multi_channel_timer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_timer.sv
// Multi-channel programmable timer: one shared prescaler feeding N up-counting
// channels, each with reload compare, one-shot mode, match flag and irq enable.
module multi_channel_timer #(
   parameter int unsigned              CHANNELS      = 4,
   parameter int unsigned              COUNTER_WIDTH = 16,
   parameter int unsigned              DIVIDER_WIDTH = 15,
   parameter logic [DIVIDER_WIDTH-1:0] INTERVAL      = 15'd24000,
   localparam int unsigned             AW            = $clog2(CHANNELS) + 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    data_in,
   input  logic          wr,
   input  logic          rd,
   output logic [7:0]    data_out,
   output logic          irq,
   output logic          tick
);

   logic [DIVIDER_WIDTH-1:0] div_q, div_d;
   logic [COUNTER_WIDTH-1:0] cnt_q [CHANNELS];
   logic [COUNTER_WIDTH-1:0] cnt_d [CHANNELS];
   logic [COUNTER_WIDTH-1:0] rld_q [CHANNELS];
   logic [COUNTER_WIDTH-1:0] rld_d [CHANNELS];
   logic [7:0]               hi_q  [CHANNELS];
   logic [7:0]               hi_d  [CHANNELS];
   logic [CHANNELS-1:0]      en_q, en_d;
   logic [CHANNELS-1:0]      os_q, os_d;
   logic [CHANNELS-1:0]      ie_q, ie_d;
   logic [CHANNELS-1:0]      flag_q, flag_d;
   logic [7:0]               dout_q, dout_d;
   logic [AW-1:0]            ch_addr;
   logic [1:0]               rsel;
   logic                     tick_w;

   // Counters narrower than 16 bits are viewed zero-extended on the byte bus.
   function automatic logic [7:0] byte_of(input logic [COUNTER_WIDTH-1:0] v, input logic hi);
      logic [15:0] t;
      t = 16'(v);
      return hi ? t[15:8] : t[7:0];
   endfunction

   function automatic logic [COUNTER_WIDTH-1:0] put_byte(input logic [COUNTER_WIDTH-1:0] v,
                                                         input logic hi, input logic [7:0] b);
      logic [15:0] t;
      t = 16'(v);
      if (hi) t[15:8] = b;
      else    t[7:0]  = b;
      return t[COUNTER_WIDTH-1:0];
   endfunction

   assign ch_addr  = addr >> 2;
   assign rsel     = addr[1:0];
   assign tick_w   = (div_q == INTERVAL);
   assign tick     = tick_w & ~reset;
   assign irq      = |(flag_q & ie_q);
   assign data_out = dout_q;

   always_comb begin
      div_d  = tick_w ? '0 : div_q + 1'b1;
      cnt_d  = cnt_q;
      rld_d  = rld_q;
      hi_d   = hi_q;
      en_d   = en_q;
      os_d   = os_q;
      ie_d   = ie_q;
      flag_d = flag_q;
      dout_d = dout_q;
      if (rd) dout_d = '0;

      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (wr && ch_addr == AW'(c) && rsel == 2'd3 && data_in[0]) flag_d[c] = 1'b0;
         if (wr && ch_addr == AW'(c) && rsel == 2'd1) rld_d[c] = put_byte(rld_q[c], 1'b0, data_in);
         if (wr && ch_addr == AW'(c) && rsel == 2'd2) rld_d[c] = put_byte(rld_q[c], 1'b1, data_in);

         // Match sets the flag after any status clear above, so set wins;
         // a ctrl write on the same clk suppresses the count step entirely.
         if (tick_w && en_q[c] && !(wr && ch_addr == AW'(c) && rsel == 2'd0)) begin
            if (cnt_q[c] == rld_q[c]) begin
               cnt_d[c]  = '0;
               flag_d[c] = 1'b1;
               if (os_q[c]) en_d[c] = 1'b0;
            end else begin
               cnt_d[c] = cnt_q[c] + 1'b1;
            end
         end

         if (wr && ch_addr == AW'(c) && rsel == 2'd0) begin
            en_d[c] = data_in[0];
            os_d[c] = data_in[1];
            ie_d[c] = data_in[2];
            if (data_in[0] && !en_q[c]) cnt_d[c] = '0;
         end

         if (rd && ch_addr == AW'(c)) begin
            case (rsel)
               2'd0: dout_d = {5'b0, ie_q[c], os_q[c], en_q[c]};
               2'd1: begin
                  dout_d  = byte_of(cnt_q[c], 1'b0);
                  hi_d[c] = byte_of(cnt_q[c], 1'b1);
               end
               2'd2: dout_d = hi_q[c];
               default: dout_d = {7'b0, flag_q[c]};
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q  <= '0;
         en_q   <= '0;
         os_q   <= '0;
         ie_q   <= '0;
         flag_q <= '0;
         dout_q <= '0;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            cnt_q[c] <= '0;
            rld_q[c] <= '0;
            hi_q[c]  <= '0;
         end
      end else begin
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         rld_q  <= rld_d;
         hi_q   <= hi_d;
         en_q   <= en_d;
         os_q   <= os_d;
         ie_q   <= ie_d;
         flag_q <= flag_d;
         dout_q <= dout_d;
      end
   end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Bench for multi_channel_timer with INTERVAL=3 (tick every 4 clks); read
// expectations are queued when a read is issued and popped when data_out returns.
module tb_multi_channel_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] addr = '0;
   logic [7:0] data_in = '0;
   logic       wr = 1'b0;
   logic       rd = 1'b0;
   logic [7:0] data_out;
   logic       irq;
   logic       tick;

   int         chk_cnt = 0;
   int         pass_cnt = 0;
   logic [7:0] exp_q[$];

   multi_channel_timer #(
      .CHANNELS(4),
      .COUNTER_WIDTH(16),
      .DIVIDER_WIDTH(15),
      .INTERVAL(15'd3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .addr(addr),
      .data_in(data_in),
      .wr(wr),
      .rd(rd),
      .data_out(data_out),
      .irq(irq),
      .tick(tick)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [3:0] A(input int ch, input int r);
      return 4'(ch * 4 + r);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      addr = a; data_in = d; wr = 1'b1;
      step();
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
      addr = a; rd = 1'b1;
      step();
      rd = 1'b0;
      d = data_out;
   endtask

   // Returns with the prescaler at INTERVAL, i.e. the next edge is a tick edge.
   task automatic wait_tick_visible();
      int n = 0;
      while (!tick && n < 16) begin
         step();
         n++;
      end
      if (!tick) begin
         chk_cnt++;
         $display("FAIL tick_timeout: tick=%b required=1 within 16 clks", tick);
      end
   endtask

   task automatic wait_tick_edge();
      wait_tick_visible();
      step();
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) wait_tick_edge();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      chk_cnt++; if (tick !== 1'b0) $display("FAIL rst_tick: got=%b exp=0", tick); else pass_cnt++;
      chk_cnt++; if (irq !== 1'b0) $display("FAIL rst_irq: got=%b exp=0", irq); else pass_cnt++;
      chk_cnt++; if (data_out !== 8'h00) $display("FAIL rst_dout: got=%h exp=00", data_out); else pass_cnt++;
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         chk_cnt++;
         if (tick !== ((k % 4) == 3)) $display("FAIL tick_period k=%0d: got=%b exp=%b", k, tick, (k % 4) == 3);
         else pass_cnt++;
         step();
      end
      chk_cnt++; if (irq !== 1'b0) $display("FAIL idle_irq: got=%b exp=0", irq); else pass_cnt++;
      chk_cnt++; if (data_out !== 8'h00) $display("FAIL idle_dout: got=%h exp=00", data_out); else pass_cnt++;
   endtask

   task automatic test_periodic();
      logic [7:0] d, e;
      wait_tick_edge();
      bus_write(A(0, 1), 8'h02);
      bus_write(A(0, 2), 8'h00);
      wait_tick_edge();
      bus_write(A(0, 0), 8'h05);
      exp_q.push_back(8'h00); bus_read(A(0, 1), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch0_cnt0: got=%h exp=%h", d, e); else pass_cnt++;
      wait_tick_edge();
      exp_q.push_back(8'h01); bus_read(A(0, 1), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch0_cnt1: got=%h exp=%h", d, e); else pass_cnt++;
      wait_tick_edge();
      exp_q.push_back(8'h02); bus_read(A(0, 1), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch0_cnt2: got=%h exp=%h", d, e); else pass_cnt++;
      chk_cnt++; if (irq !== 1'b0) $display("FAIL ch0_irq_early: got=%b exp=0", irq); else pass_cnt++;
      wait_tick_edge();
      chk_cnt++; if (irq !== 1'b1) $display("FAIL ch0_irq_set: got=%b exp=1", irq); else pass_cnt++;
      exp_q.push_back(8'h00); bus_read(A(0, 1), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch0_cnt_wrap: got=%h exp=%h", d, e); else pass_cnt++;
      exp_q.push_back(8'h01); bus_read(A(0, 3), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch0_flag: got=%h exp=%h", d, e); else pass_cnt++;
      chk_cnt++; if (irq !== 1'b1) $display("FAIL ch0_irq_hold: got=%b exp=1", irq); else pass_cnt++;
      bus_write(A(0, 3), 8'h01);
      chk_cnt++; if (irq !== 1'b0) $display("FAIL ch0_irq_clear: got=%b exp=0", irq); else pass_cnt++;
      bus_write(A(0, 0), 8'h00);
   endtask

   task automatic test_one_shot();
      logic [7:0] d, e;
      wait_tick_edge();
      bus_write(A(1, 1), 8'h01);
      bus_write(A(1, 2), 8'h00);
      wait_tick_edge();
      bus_write(A(1, 0), 8'h03);
      wait_tick_edge();
      exp_q.push_back(8'h01); bus_read(A(1, 1), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch1_cnt1: got=%h exp=%h", d, e); else pass_cnt++;
      wait_tick_edge();
      exp_q.push_back(8'h02); bus_read(A(1, 0), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch1_ctrl_after: got=%h exp=%h", d, e); else pass_cnt++;
      exp_q.push_back(8'h01); bus_read(A(1, 3), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch1_flag: got=%h exp=%h", d, e); else pass_cnt++;
      chk_cnt++; if (irq !== 1'b0) $display("FAIL ch1_irq_masked: got=%b exp=0", irq); else pass_cnt++;
      wait_ticks(10);
      exp_q.push_back(8'h00); bus_read(A(1, 1), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch1_stopped_lo: got=%h exp=%h", d, e); else pass_cnt++;
      exp_q.push_back(8'h00); bus_read(A(1, 2), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch1_stopped_hi: got=%h exp=%h", d, e); else pass_cnt++;
   endtask

   task automatic test_coherent();
      logic [7:0] d, e;
      wait_tick_edge();
      bus_write(A(2, 1), 8'hFF);
      bus_write(A(2, 2), 8'hFF);
      bus_write(A(2, 0), 8'h01);
      wait_ticks(511);
      exp_q.push_back(8'hFF); bus_read(A(2, 1), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch2_lo_1ff: got=%h exp=%h", d, e); else pass_cnt++;
      wait_tick_edge();
      exp_q.push_back(8'h01); bus_read(A(2, 2), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch2_hi_latched: got=%h exp=%h", d, e); else pass_cnt++;
      exp_q.push_back(8'h00); bus_read(A(2, 1), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch2_lo_200: got=%h exp=%h", d, e); else pass_cnt++;
      exp_q.push_back(8'h02); bus_read(A(2, 2), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch2_hi_200: got=%h exp=%h", d, e); else pass_cnt++;
   endtask

   task automatic test_simultaneous();
      logic [7:0] d, e;
      wait_tick_edge();
      bus_write(A(3, 1), 8'h00);
      bus_write(A(3, 2), 8'h00);
      bus_write(A(3, 0), 8'h01);
      wait_tick_edge();
      bus_write(A(3, 3), 8'h01);
      exp_q.push_back(8'h00); bus_read(A(3, 3), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch3_plain_clear: got=%h exp=%h", d, e); else pass_cnt++;
      wait_tick_visible();
      bus_write(A(3, 3), 8'h01);
      exp_q.push_back(8'h01); bus_read(A(3, 3), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch3_set_beats_clear: got=%h exp=%h", d, e); else pass_cnt++;
      bus_write(A(3, 0), 8'h00);
      bus_write(A(3, 3), 8'h01);
      bus_write(A(3, 1), 8'hFF);
      bus_write(A(3, 0), 8'h01);
      wait_ticks(2);
      wait_tick_visible();
      bus_write(A(3, 0), 8'h01);
      exp_q.push_back(8'h02); bus_read(A(3, 1), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch3_ctrl_skip: got=%h exp=%h", d, e); else pass_cnt++;
      wait_tick_edge();
      exp_q.push_back(8'h03); bus_read(A(3, 1), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL ch3_resume: got=%h exp=%h", d, e); else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      logic [7:0] d, e;
      bus_write(A(0, 0), 8'h05);
      wait_tick_edge();
      step();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      chk_cnt++; if (data_out !== 8'h00) $display("FAIL mr_dout: got=%h exp=00", data_out); else pass_cnt++;
      chk_cnt++; if (irq !== 1'b0) $display("FAIL mr_irq: got=%b exp=0", irq); else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
         chk_cnt++;
         if (tick !== (k == 3)) $display("FAIL mr_tick k=%0d: got=%b exp=%b", k, tick, k == 3);
         else pass_cnt++;
         step();
      end
      for (int ch = 0; ch < 4; ch++) begin
         for (int r = 0; r < 4; r++) begin
            exp_q.push_back(8'h00); bus_read(A(ch, r), d); e = exp_q.pop_front();
            chk_cnt++;
            if (d !== e) $display("FAIL mr_reg ch%0d r%0d: got=%h exp=%h", ch, r, d, e);
            else pass_cnt++;
         end
      end
      wait_ticks(3);
      exp_q.push_back(8'h00); bus_read(A(2, 1), d); e = exp_q.pop_front();
      chk_cnt++; if (d !== e) $display("FAIL mr_ch2_idle: got=%h exp=%h", d, e); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_one_shot();
      test_coherent();
      test_simultaneous();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
